// File: rtl/freelist_pkg.sv
// Shared constants and packet types for the physical-register free list.
// The dispatch and ROB packet layouts are shared with the neighbouring pipeline stages.
package freelist_pkg;

    localparam int WAYS       = 3;
    localparam int N_PHYS_REG = 64;
    localparam int N_ARCH_REG = 32;
    localparam int DEPTH      = N_PHYS_REG - N_ARCH_REG;
    localparam int PR_W       = $clog2(N_PHYS_REG);
    localparam int PTR_W      = $clog2(DEPTH);
    localparam int CNT_W      = PTR_W + 1;
    localparam int WAY_CNT_W  = $clog2(WAYS + 1);

    typedef struct packed {
        logic [WAYS-1:0][PR_W-1:0] t_idx;
        logic [WAYS-1:0]           avail;
        logic [CNT_W-1:0]          free_count;
    } freelist_dispatch_packet_t;

    typedef struct packed {
        logic [WAYS-1:0]           retire_en;
        logic [WAYS-1:0][PR_W-1:0] retire_told_idx;
    } rob_freelist_packet_t;

endpackage

// File: rtl/freelist_checker.sv
// Protocol checks on the free list: no over-allocation, no release into a full list.
module freelist_checker
    import freelist_pkg::*;
(
    input logic                 clock,
    input logic                 reset,
    input logic                 branch_flush_en,
    input logic [WAY_CNT_W-1:0] n_alloc_req,
    input logic [WAY_CNT_W-1:0] n_rel,
    input logic [CNT_W-1:0]     count
);

    // Sample the handshake each cycle outside reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (branch_flush_en || (CNT_W'(n_alloc_req) <= count))
                else $error("freelist: allocation request exceeds free count");
            assert (!((count == CNT_W'(DEPTH)) && (n_rel != {WAY_CNT_W{1'b0}})))
                else $error("freelist: release while list is full");
        end else begin
        end
    end

endmodule

// File: rtl/freelist_compact.sv
// Prefix popcount: compacted write offsets for pushing slots, plus push and allocate totals.
// Kept generic in width so the ROB can reuse it.
module freelist_compact #(
    parameter int WAYS = 3,
    parameter int CW   = $clog2(WAYS + 1)
) (
    input  logic [WAYS-1:0]         alloc_en,
    input  logic [WAYS-1:0]         push_en,
    output logic [WAYS-1:0][CW-1:0] offset,
    output logic [CW-1:0]           n_push,
    output logic [CW-1:0]           n_alloc
);

    logic [CW-1:0] push_run_s;
    logic [CW-1:0] alloc_run_s;

    // Running count of lower pushing slots gives each slot its write offset.
    always_comb begin
        push_run_s  = {CW{1'b0}};
        alloc_run_s = {CW{1'b0}};
        for (int i = 0; i < WAYS; i++) begin
            offset[i]   = push_run_s;
            push_run_s  = push_run_s + CW'(push_en[i]);
            alloc_run_s = alloc_run_s + CW'(alloc_en[i]);
        end
        n_push  = push_run_s;
        n_alloc = alloc_run_s;
    end

endmodule

// File: rtl/freelist.sv
// Circular free list of physical register tags shared by dispatch and retirement,
// with allocation pointer recovery to the retired state on branch flush.
module freelist
    import freelist_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset,
    input  logic [WAYS-1:0]            new_pr_en,
    input  logic [WAYS-1:0]            retire_en,
    input  logic [WAYS-1:0][PR_W-1:0]  retire_told_idx,
    input  logic                       branch_flush_en,
    output logic [WAYS-1:0][PR_W-1:0]  t_idx,
    output logic [WAYS-1:0]            avail,
    output logic [CNT_W-1:0]           free_count
);

    logic [PR_W-1:0]               entry_r [DEPTH];
    logic [PTR_W-1:0]              head_r;
    logic [PTR_W-1:0]              tail_r;
    logic [PTR_W-1:0]              arch_head_r;
    logic [CNT_W-1:0]              count_r;

    rob_freelist_packet_t          rob_pkt_s;
    freelist_dispatch_packet_t     disp_pkt_s;
    logic [WAYS-1:0]               push_s;
    logic [WAYS-1:0][WAY_CNT_W-1:0] offset_s;
    logic [WAY_CNT_W-1:0]          n_rel_s;
    logic [WAY_CNT_W-1:0]          n_alloc_req_s;
    logic [CNT_W-1:0]              n_alloc_s;
    logic [WAYS-1:0][PTR_W-1:0]    wr_ptr_s;
    logic [PTR_W-1:0]              head_next_s;
    logic [PTR_W-1:0]              tail_next_s;
    logic [PTR_W-1:0]              arch_head_next_s;
    logic [CNT_W-1:0]              count_next_s;

    assign rob_pkt_s.retire_en       = retire_en;
    assign rob_pkt_s.retire_told_idx = retire_told_idx;

    // PR0 is the hardwired zero register and never re-enters the pool.
    always_comb begin
        for (int i = 0; i < WAYS; i++) begin
            push_s[i] = rob_pkt_s.retire_en[i] &&
                        (rob_pkt_s.retire_told_idx[i] != {PR_W{1'b0}});
        end
    end

    freelist_compact #(
        .WAYS (WAYS),
        .CW   (WAY_CNT_W)
    ) u_compact (
        .alloc_en (new_pr_en),
        .push_en  (push_s),
        .offset   (offset_s),
        .n_push   (n_rel_s),
        .n_alloc  (n_alloc_req_s)
    );

    // Next-state pointers and count; flush rewinds head to the retired allocation point.
    always_comb begin
        tail_next_s      = tail_r + PTR_W'(n_rel_s);
        arch_head_next_s = arch_head_r + PTR_W'(n_rel_s);
        for (int i = 0; i < WAYS; i++) begin
            wr_ptr_s[i] = tail_r + PTR_W'(offset_s[i]);
        end
        if (CNT_W'(n_alloc_req_s) > count_r) begin
            n_alloc_s = count_r;
        end else begin
            n_alloc_s = CNT_W'(n_alloc_req_s);
        end
        if (branch_flush_en) begin
            head_next_s  = arch_head_next_s;
            count_next_s = CNT_W'(DEPTH) - {1'b0, tail_next_s - arch_head_next_s};
        end else begin
            head_next_s  = head_r + n_alloc_s[PTR_W-1:0];
            count_next_s = count_r - n_alloc_s + CNT_W'(n_rel_s);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_r      <= {PTR_W{1'b0}};
            tail_r      <= {PTR_W{1'b0}};
            arch_head_r <= {PTR_W{1'b0}};
            count_r     <= CNT_W'(DEPTH);
        end else begin
            head_r      <= head_next_s;
            tail_r      <= tail_next_s;
            arch_head_r <= arch_head_next_s;
            count_r     <= count_next_s;
        end
    end

    // Tag storage: reset seeds the PRs above the initial architectural map.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                entry_r[k] <= PR_W'(N_ARCH_REG + k);
            end
        end else begin
            for (int i = 0; i < WAYS; i++) begin
                if (push_s[i]) begin
                    entry_r[wr_ptr_s[i]] <= rob_pkt_s.retire_told_idx[i];
                end else begin
                end
            end
        end
    end

    // Dispatch view comes straight from registered state; no release bypass.
    always_comb begin
        disp_pkt_s.free_count = count_r;
        for (int k = 0; k < WAYS; k++) begin
            disp_pkt_s.t_idx[k] = entry_r[head_r + PTR_W'(k)];
            disp_pkt_s.avail[k] = (count_r > CNT_W'(k));
        end
    end

    assign t_idx      = disp_pkt_s.t_idx;
    assign avail      = disp_pkt_s.avail;
    assign free_count = disp_pkt_s.free_count;

    freelist_checker u_checker (
        .clock           (clock),
        .reset           (reset),
        .branch_flush_en (branch_flush_en),
        .n_alloc_req     (n_alloc_req_s),
        .n_rel           (n_rel_s),
        .count           (count_r)
    );

endmodule

// File: tb/tb_freelist.sv
// Directed bench for freelist: reset pool, allocation, drain/refill, wrap-around and flush.
module tb_freelist;

    logic             clock = 1'b0;
    logic             reset;
    logic [2:0]       new_pr_en;
    logic [2:0]       retire_en;
    logic [2:0][5:0]  retire_told_idx;
    logic             branch_flush_en;
    logic [2:0][5:0]  t_idx;
    logic [2:0]       avail;
    logic [5:0]       free_count;

    int checks = 0;
    int errors = 0;

    freelist dut (
        .clock           (clock),
        .reset           (reset),
        .new_pr_en       (new_pr_en),
        .retire_en       (retire_en),
        .retire_told_idx (retire_told_idx),
        .branch_flush_en (branch_flush_en),
        .t_idx           (t_idx),
        .avail           (avail),
        .free_count      (free_count)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        new_pr_en       = 3'b000;
        retire_en       = 3'b000;
        retire_told_idx = '0;
        branch_flush_en = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Tag expected at absolute head position h in the wrap test.
    function automatic int wrap_tag(input int h);
        if (h < 32) return 32 + h;
        return ((h - 32) % 62) + 1;
    endfunction

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Initial pool.
        check_eq("rst_t0", int'(t_idx[0]), 32);
        check_eq("rst_t1", int'(t_idx[1]), 33);
        check_eq("rst_t2", int'(t_idx[2]), 34);
        check_eq("rst_avail", int'(avail), 7);
        check_eq("rst_count", int'(free_count), 32);

        // Sparse allocation consumes two tags.
        new_pr_en = 3'b101;
        tick();
        new_pr_en = 3'b000;
        check_eq("alloc_t0", int'(t_idx[0]), 34);
        check_eq("alloc_t1", int'(t_idx[1]), 35);
        check_eq("alloc_t2", int'(t_idx[2]), 36);
        check_eq("alloc_count", int'(free_count), 30);

        // Drain to empty, then release one tag (told 0 is dropped).
        repeat (10) begin
            new_pr_en = 3'b111;
            tick();
        end
        new_pr_en = 3'b000;
        check_eq("empty_avail", int'(avail), 0);
        check_eq("empty_count", int'(free_count), 0);
        retire_en          = 3'b011;
        retire_told_idx[0] = 6'd5;
        retire_told_idx[1] = 6'd0;
        tick();
        idle_inputs();
        check_eq("refill_count", int'(free_count), 1);
        check_eq("refill_t0", int'(t_idx[0]), 5);
        check_eq("refill_avail", int'(avail), 1);

        // Reset overrides a simultaneous flush, allocation and release.
        reset              = 1'b1;
        branch_flush_en    = 1'b1;
        new_pr_en          = 3'b111;
        retire_en          = 3'b111;
        retire_told_idx[0] = 6'd20;
        retire_told_idx[1] = 6'd21;
        retire_told_idx[2] = 6'd22;
        tick();
        idle_inputs();
        reset = 1'b0;
        check_eq("midrst_t0", int'(t_idx[0]), 32);
        check_eq("midrst_count", int'(free_count), 32);
        check_eq("midrst_avail", int'(avail), 7);

        // Wrap: 2 allocations and 2 releases per cycle for 40 cycles.
        new_pr_en = 3'b011;
        tick();
        for (int i = 0; i < 40; i++) begin
            check_eq($sformatf("wrap_count_%0d", i), int'(free_count), 30);
            check_eq($sformatf("wrap_t0_%0d", i), int'(t_idx[0]), wrap_tag(2 + 2 * i));
            check_eq($sformatf("wrap_t1_%0d", i), int'(t_idx[1]), wrap_tag(3 + 2 * i));
            new_pr_en          = 3'b011;
            retire_en          = 3'b011;
            retire_told_idx[0] = 6'(((2 * i) % 62) + 1);
            retire_told_idx[1] = 6'(((2 * i + 1) % 62) + 1);
            tick();
        end
        idle_inputs();
        check_eq("wrap_count_end", int'(free_count), 30);

        // Allocate 6, retire 2 (compacted over a disabled slot), then flush.
        do_reset();
        new_pr_en = 3'b111;
        tick();
        tick();
        new_pr_en          = 3'b000;
        retire_en          = 3'b101;
        retire_told_idx[0] = 6'd7;
        retire_told_idx[1] = 6'd40;
        retire_told_idx[2] = 6'd9;
        tick();
        idle_inputs();
        check_eq("ret_count", int'(free_count), 28);
        branch_flush_en = 1'b1;
        tick();
        idle_inputs();
        // head rewinds to 2; tail equals arch_head so the whole ring is free.
        check_eq("flush_t0", int'(t_idx[0]), 34);
        check_eq("flush_t1", int'(t_idx[1]), 35);
        check_eq("flush_count", int'(free_count), 32);
        check_eq("flush_avail", int'(avail), 7);
        repeat (10) begin
            new_pr_en = 3'b111;
            tick();
        end
        new_pr_en = 3'b000;
        check_eq("flush_wrap_t0", int'(t_idx[0]), 7);
        check_eq("flush_wrap_t1", int'(t_idx[1]), 9);
        check_eq("flush_wrap_avail", int'(avail), 3);

        // Flush with a same-cycle release and an ignored allocation request.
        do_reset();
        new_pr_en = 3'b111;
        tick();
        branch_flush_en    = 1'b1;
        new_pr_en          = 3'b111;
        retire_en          = 3'b001;
        retire_told_idx[0] = 6'd12;
        tick();
        idle_inputs();
        check_eq("fr_count", int'(free_count), 32);
        check_eq("fr_t0", int'(t_idx[0]), 33);
        check_eq("fr_avail", int'(avail), 7);
        repeat (10) begin
            new_pr_en = 3'b111;
            tick();
        end
        new_pr_en = 3'b000;
        check_eq("fr_tail_t0", int'(t_idx[0]), 63);
        check_eq("fr_tail_t1", int'(t_idx[1]), 12);
        check_eq("fr_tail_avail", int'(avail), 3);
        check_eq("fr_tail_count", int'(free_count), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
